// File: rtl/updownstream_scheduler.sv
// rtl/updownstream_scheduler.sv - single-grant scheduler between CPU/exchange requesters and the order processor
//
// Ports:
//   clk, HRESETn              system clock, synchronous active-low reset
//   cpu_req_*                 CPU request channel (valid/ready, new_max, client id, 32-bit amount)
//   ex_req_*                  exchange request channel (valid/ready, client id, 16-bit amount)
//   cpu_go, cpu_new_max,      stretched go strobe and latched payload, CPU channel
//   cpu_client_id, cpu_amount
//   exchange_go,              stretched go strobe and latched payload, exchange channel
//   exchange_client_id, exchange_amount
//   busy                      high while a pulse or its dead-time gap is in progress
//   cpu_grant_count,          wrapping grant counters per channel
//   ex_grant_count
module updownstream_scheduler #(
  parameter int GO_CYCLES  = 4,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_WAIT   = 3
) (
  input  logic        clk,
  input  logic        HRESETn,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_new_max,
  input  logic [4:0]  cpu_req_client_id,
  input  logic [31:0] cpu_req_amount,
  input  logic        ex_req_valid,
  output logic        ex_req_ready,
  input  logic [4:0]  ex_req_client_id,
  input  logic [15:0] ex_req_amount,
  output logic        cpu_go,
  output logic        cpu_new_max,
  output logic [4:0]  cpu_client_id,
  output logic [31:0] cpu_amount,
  output logic        exchange_go,
  output logic [4:0]  exchange_client_id,
  output logic [15:0] exchange_amount,
  output logic        busy,
  output logic [15:0] cpu_grant_count,
  output logic [15:0] ex_grant_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // One timer serves both the go hold and the dead-time gap.
  localparam int TMAX = (GO_CYCLES > GAP_CYCLES) ? GO_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam int WW   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [TW-1:0] GO_LAST  = TW'(GO_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  state_t          state;
  logic [TW-1:0]   timer;
  logic [WW-1:0]   cpu_wait_cnt;

  // Exchange wins unless the CPU has already lost MAX_WAIT times in a row.
  assign ex_req_ready  = (state == S_IDLE) && ex_req_valid &&
                         !(cpu_req_valid && (cpu_wait_cnt == WAIT_MAX));
  assign cpu_req_ready = (state == S_IDLE) && cpu_req_valid && !ex_req_ready;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      state              <= S_IDLE;
      timer              <= '0;
      cpu_wait_cnt       <= '0;
      cpu_go             <= 1'b0;
      cpu_new_max        <= 1'b0;
      cpu_client_id      <= '0;
      cpu_amount         <= '0;
      exchange_go        <= 1'b0;
      exchange_client_id <= '0;
      exchange_amount    <= '0;
      cpu_grant_count    <= '0;
      ex_grant_count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_req_ready) begin
            exchange_client_id <= ex_req_client_id;
            exchange_amount    <= ex_req_amount;
            exchange_go        <= 1'b1;
            ex_grant_count     <= ex_grant_count + 16'd1;
            // Only a CPU that is actually waiting accumulates losses.
            if (cpu_req_valid && (cpu_wait_cnt != WAIT_MAX))
              cpu_wait_cnt <= cpu_wait_cnt + WW'(1);
            timer <= '0;
            state <= S_ISSUE;
          end else if (cpu_req_ready) begin
            cpu_new_max     <= cpu_req_new_max;
            cpu_client_id   <= cpu_req_client_id;
            cpu_amount      <= cpu_req_amount;
            cpu_go          <= 1'b1;
            cpu_grant_count <= cpu_grant_count + 16'd1;
            cpu_wait_cnt    <= '0;
            timer           <= '0;
            state           <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (timer == GO_LAST) begin
            cpu_go      <= 1'b0;
            exchange_go <= 1'b0;
            timer       <= '0;
            state       <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            state <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          cpu_go      <= 1'b0;
          exchange_go <= 1'b0;
          timer       <= '0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updownstream_scheduler.sv
// tb/tb_updownstream_scheduler.sv - self-checking bench for updownstream_scheduler
module tb_updownstream_scheduler;

  localparam int GO   = 4;
  localparam int GAP  = 4;
  localparam int MAXW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        HRESETn;
  logic        cpu_req_valid, cpu_req_new_max;
  logic [4:0]  cpu_req_client_id;
  logic [31:0] cpu_req_amount;
  logic        ex_req_valid;
  logic [4:0]  ex_req_client_id;
  logic [15:0] ex_req_amount;
  logic        cpu_req_ready, ex_req_ready;
  logic        cpu_go, cpu_new_max, exchange_go, busy;
  logic [4:0]  cpu_client_id, exchange_client_id;
  logic [31:0] cpu_amount;
  logic [15:0] exchange_amount, cpu_grant_count, ex_grant_count;

  // Second instance: one-cycle pulses, no dead time.
  logic        cpu_valid2, ex_valid2;
  logic        cpu_ready2, ex_ready2, cpu_go2, cpu_new_max2, exchange_go2, busy2;
  logic [4:0]  cpu_client_id2, exchange_client_id2;
  logic [31:0] cpu_amount2;
  logic [15:0] exchange_amount2, cpu_grant_count2, ex_grant_count2;

  updownstream_scheduler #(.GO_CYCLES(GO), .GAP_CYCLES(GAP), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .HRESETn(HRESETn),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_new_max(cpu_req_new_max), .cpu_req_client_id(cpu_req_client_id),
    .cpu_req_amount(cpu_req_amount),
    .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready),
    .ex_req_client_id(ex_req_client_id), .ex_req_amount(ex_req_amount),
    .cpu_go(cpu_go), .cpu_new_max(cpu_new_max), .cpu_client_id(cpu_client_id),
    .cpu_amount(cpu_amount), .exchange_go(exchange_go),
    .exchange_client_id(exchange_client_id), .exchange_amount(exchange_amount),
    .busy(busy), .cpu_grant_count(cpu_grant_count), .ex_grant_count(ex_grant_count)
  );

  updownstream_scheduler #(.GO_CYCLES(1), .GAP_CYCLES(0), .MAX_WAIT(1)) dut2 (
    .clk(clk), .HRESETn(HRESETn),
    .cpu_req_valid(cpu_valid2), .cpu_req_ready(cpu_ready2),
    .cpu_req_new_max(1'b0), .cpu_req_client_id(5'd2),
    .cpu_req_amount(32'd7),
    .ex_req_valid(ex_valid2), .ex_req_ready(ex_ready2),
    .ex_req_client_id(5'd4), .ex_req_amount(16'd9),
    .cpu_go(cpu_go2), .cpu_new_max(cpu_new_max2), .cpu_client_id(cpu_client_id2),
    .cpu_amount(cpu_amount2), .exchange_go(exchange_go2),
    .exchange_client_id(exchange_client_id2), .exchange_amount(exchange_amount2),
    .busy(busy2), .cpu_grant_count(cpu_grant_count2), .ex_grant_count(ex_grant_count2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: timing expressed as absolute cycle numbers.
  int          cyc = 0;
  int          m_acc = -1000;   // cycle of the edge that accepted the last grant
  int          m_free = 0;      // first cycle in which a new accept is allowed
  bit          m_win_cpu = 1'b0;
  int          m_wait = 0;
  logic        m_new_max;
  logic [4:0]  m_cid, m_eid;
  logic [31:0] m_camt;
  logic [15:0] m_eamt, m_ccnt, m_ecnt;
  bit          acc_cpu, acc_ex;
  int          acc_cyc[$];
  byte         acc_who[$];
  bit          chk2 = 1'b0;
  int          k2 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit e_idle, e_ex, e_cpu, in_go;
    @(negedge clk);
    e_idle = (cyc >= m_free);
    e_ex   = e_idle && ex_req_valid && !(cpu_req_valid && (m_wait == MAXW));
    e_cpu  = e_idle && cpu_req_valid && !e_ex;
    in_go  = (cyc > m_acc) && (cyc <= m_acc + GO);
    if (HRESETn) begin
      check("ex_req_ready", {31'd0, ex_req_ready}, {31'd0, e_ex});
      check("cpu_req_ready", {31'd0, cpu_req_ready}, {31'd0, e_cpu});
      check("cpu_go", {31'd0, cpu_go}, {31'd0, in_go && m_win_cpu});
      check("exchange_go", {31'd0, exchange_go}, {31'd0, in_go && !m_win_cpu});
      check("busy", {31'd0, busy}, {31'd0, (cyc > m_acc) && (cyc < m_free)});
      check("go_exclusive", {31'd0, cpu_go & exchange_go}, 32'd0);
      check("cpu_new_max", {31'd0, cpu_new_max}, {31'd0, m_new_max});
      check("cpu_client_id", {27'd0, cpu_client_id}, {27'd0, m_cid});
      check("cpu_amount", cpu_amount, m_camt);
      check("exchange_client_id", {27'd0, exchange_client_id}, {27'd0, m_eid});
      check("exchange_amount", {16'd0, exchange_amount}, {16'd0, m_eamt});
      check("cpu_grant_count", {16'd0, cpu_grant_count}, {16'd0, m_ccnt});
      check("ex_grant_count", {16'd0, ex_grant_count}, {16'd0, m_ecnt});
    end
    if (chk2) begin
      check("d2_ex_ready", {31'd0, ex_ready2}, {31'd0, (k2 % 2) == 0});
      check("d2_exchange_go", {31'd0, exchange_go2}, {31'd0, (k2 % 2) == 1});
      check("d2_cpu_go", {31'd0, cpu_go2}, 32'd0);
      k2++;
    end
    @(posedge clk);
    acc_cpu = 1'b0;
    acc_ex  = 1'b0;
    if (!HRESETn) begin
      m_acc = -1000; m_free = cyc + 1; m_wait = 0; m_win_cpu = 1'b0;
      m_new_max = 1'b0; m_cid = '0; m_camt = '0; m_eid = '0; m_eamt = '0;
      m_ccnt = '0; m_ecnt = '0;
    end else if (e_ex) begin
      acc_ex = 1'b1; m_win_cpu = 1'b0; m_acc = cyc; m_free = cyc + GO + GAP + 1;
      m_eid = ex_req_client_id; m_eamt = ex_req_amount; m_ecnt = m_ecnt + 16'd1;
      if (cpu_req_valid && m_wait < MAXW) m_wait++;
      acc_cyc.push_back(cyc); acc_who.push_back("E");
    end else if (e_cpu) begin
      acc_cpu = 1'b1; m_win_cpu = 1'b1; m_acc = cyc; m_free = cyc + GO + GAP + 1;
      m_new_max = cpu_req_new_max; m_cid = cpu_req_client_id; m_camt = cpu_req_amount;
      m_ccnt = m_ccnt + 16'd1; m_wait = 0;
      acc_cyc.push_back(cyc); acc_who.push_back("C");
    end
    cyc++;
    #1;
  endtask

  task automatic rst(input int n);
    HRESETn = 1'b0;
    repeat (n) step();
    HRESETn = 1'b1;
  endtask

  initial begin
    string exp_order;
    int    n, guard;

    HRESETn = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_new_max = 1'b0; cpu_req_client_id = '0; cpu_req_amount = '0;
    ex_req_valid = 1'b0; ex_req_client_id = '0; ex_req_amount = '0;
    cpu_valid2 = 1'b0; ex_valid2 = 1'b0;

    // Reset state, then a single CPU request.
    rst(2);
    step();
    cpu_req_valid = 1'b1; cpu_req_new_max = 1'b1; cpu_req_client_id = 5'd5; cpu_req_amount = 32'h0000_1000;
    step();
    cpu_req_valid = 1'b0;
    repeat (10) step();
    check("t1_cpu_grant_count", {16'd0, cpu_grant_count}, 32'd1);
    check("t1_cpu_client_id", {27'd0, cpu_client_id}, 32'd5);
    check("t1_cpu_amount", cpu_amount, 32'h0000_1000);
    check("t1_cpu_new_max", {31'd0, cpu_new_max}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // Both sides valid continuously: starvation guard ordering and grant period.
    rst(1);
    acc_cyc.delete(); acc_who.delete();
    cpu_req_valid = 1'b1; cpu_req_new_max = 1'b0; cpu_req_client_id = 5'd9; cpu_req_amount = 32'hCAFE_0001;
    ex_req_valid = 1'b1; ex_req_client_id = 5'd3; ex_req_amount = 16'h0055;
    guard = 0;
    while (acc_cyc.size() < 8 && guard < 120) begin step(); guard++; end
    check("t2_grants", acc_cyc.size(), 32'd8);
    exp_order = "EEECEEEC";
    for (int i = 0; i < 8 && i < acc_cyc.size(); i++) begin
      check("t2_winner", {24'd0, acc_who[i]}, {24'd0, exp_order[i]});
      if (i > 0) check("t2_period", acc_cyc[i] - acc_cyc[i-1], GO + GAP + 1);
    end
    cpu_req_valid = 1'b0; ex_req_valid = 1'b0;
    repeat (10) step();

    // Exchange-only back-to-back requests.
    rst(1);
    acc_cyc.delete(); acc_who.delete();
    ex_req_valid = 1'b1; ex_req_client_id = 5'd1; ex_req_amount = 16'h00FF;
    n = 0; guard = 0;
    while (n < 3 && guard < 60) begin
      step(); guard++;
      if (acc_ex) begin
        n++;
        if (n < 3) ex_req_client_id = 5'(n + 1);
        else ex_req_valid = 1'b0;
      end
    end
    check("t3_grants", n, 32'd3);
    if (acc_cyc.size() == 3) begin
      check("t3_start2", acc_cyc[1] - acc_cyc[0], 32'd9);
      check("t3_start3", acc_cyc[2] - acc_cyc[0], 32'd18);
    end
    repeat (10) step();
    check("t3_ex_grant_count", {16'd0, ex_grant_count}, 32'd3);
    check("t3_exchange_amount", {16'd0, exchange_amount}, 32'h00FF);
    check("t3_exchange_client_id", {27'd0, exchange_client_id}, 32'd3);
    check("t3_cpu_wait_cnt", {30'd0, dut.cpu_wait_cnt}, 32'd0);

    // One-cycle pulses, no gap: accept every second cycle.
    ex_valid2 = 1'b1; chk2 = 1'b1; k2 = 0;
    repeat (20) step();
    ex_valid2 = 1'b0; chk2 = 1'b0;
    step();

    // Reset during the second ISSUE cycle with a request pending.
    rst(1);
    ex_req_valid = 1'b1; ex_req_client_id = 5'd7; ex_req_amount = 16'h1234;
    guard = 0;
    do begin step(); guard++; end while (!acc_ex && guard < 5);
    check("t5_first_accept", {31'd0, acc_ex}, 32'd1);
    ex_req_client_id = 5'd8; ex_req_amount = 16'h4321;
    step();
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    check("t5_go_dropped", {31'd0, exchange_go}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_ex_grant_count", {16'd0, ex_grant_count}, 32'd0);
    step();
    check("t5_reaccept", {31'd0, acc_ex}, 32'd1);
    check("t5_ex_client_id", {27'd0, exchange_client_id}, 32'd8);
    ex_req_valid = 1'b0;
    repeat (10) step();

    // Grant counter wrap.
    force dut.ex_grant_count = 16'hFFFF;
    #1;
    release dut.ex_grant_count;
    m_ecnt = 16'hFFFF;
    ex_req_valid = 1'b1; ex_req_client_id = 5'd11; ex_req_amount = 16'h0A0A;
    guard = 0;
    do begin step(); guard++; end while (!acc_ex && guard < 5);
    ex_req_valid = 1'b0;
    check("t6_wrap", {16'd0, ex_grant_count}, 32'd0);
    repeat (10) step();

    // Randomized traffic against the model.
    rst(1);
    for (int i = 0; i < 600; i++) begin
      if (acc_cpu || !cpu_req_valid) begin
        cpu_req_valid = ($urandom_range(0, 2) != 0);
        cpu_req_new_max = 1'($urandom);
        cpu_req_client_id = 5'($urandom);
        cpu_req_amount = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        cpu_req_valid = 1'b0;
      end
      if (acc_ex || !ex_req_valid) begin
        ex_req_valid = ($urandom_range(0, 2) != 0);
        ex_req_client_id = 5'($urandom);
        ex_req_amount = 16'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        ex_req_valid = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/updownstream_scheduler.md
Name: updownstream_scheduler

Overview:
- Sits between the CPU command source, the exchange feed and the up/downstream order processor.
- Only one request reaches the processor at a time; cpu_go and exchange_go are never both active.
- Each go pulse is stretched so the slow processor clock samples it, followed by a dead-time gap.
- Exchange traffic has priority. A starvation guard bounds CPU wait.

Parameters:
- GO_CYCLES, 4, clk cycles the go pulse is held (≥1; at least one slowclk period)
- GAP_CYCLES, 4, idle clk cycles after a go pulse before the next grant (0 allowed)
- MAX_WAIT, 3, consecutive CPU losses before the CPU is forced to win (≥1)

Ports:
- clk  in  1  system clock
- HRESETn  in  1  synchronous active-low reset
- cpu_req_valid  in  1  CPU request pending
- cpu_req_ready  out  1  CPU request accepted this cycle when high with valid
- cpu_req_new_max  in  1  request is a max_to_trade update
- cpu_req_client_id  in  5  CPU client id
- cpu_req_amount  in  32  CPU amount
- ex_req_valid  in  1  exchange request pending
- ex_req_ready  out  1  exchange request accepted this cycle when high with valid
- ex_req_client_id  in  5  exchange client id
- ex_req_amount  in  16  exchange amount
- cpu_go  out  1  go strobe to processor, CPU channel
- cpu_new_max  out  1  latched new_max
- cpu_client_id  out  5  latched CPU client id
- cpu_amount  out  32  latched CPU amount
- exchange_go  out  1  go strobe to processor, exchange channel
- exchange_client_id  out  5  latched exchange client id
- exchange_amount  out  16  latched exchange amount
- busy  out  1  high in ISSUE or GAP
- cpu_grant_count  out  16  CPU grants since reset, wraps
- ex_grant_count  out  16  exchange grants since reset, wraps

Behaviour:

Clock and reset:
- Single clock, clk. Reset HRESETn is synchronous and active-low.
- While HRESETn=0 at a clk edge, all of the following are 0: outputs, state (IDLE), timer and cpu_wait_cnt.
- A reset mid-ISSUE drops go on that edge. No pulse is completed or replayed.

State machine (IDLE, ISSUE, GAP):
- ready signals are combinational and nonzero only in IDLE.
  - ex_req_ready = ex_req_valid && !(cpu_req_valid && cpu_wait_cnt==MAX_WAIT)
  - cpu_req_ready = cpu_req_valid && !ex_req_ready
  - At most one ready is high in any cycle.
- Accept at edge T (IDLE, valid && ready):
  - Latch the winner's payload into its output registers.
  - The loser's payload registers are unchanged.
  - Go to ISSUE and increment the winner's grant counter.
- ISSUE:
  - The winner's go is high for exactly GO_CYCLES cycles, T+1..T+GO_CYCLES.
  - The other go stays 0.
- GAP:
  - Lasts GAP_CYCLES cycles. Both go signals are 0.
  - If GAP_CYCLES=0, go straight from ISSUE to IDLE.
- The next accept is possible at edge T+GO_CYCLES+GAP_CYCLES+1. The sustained grant period is GO_CYCLES+GAP_CYCLES+1 cycles.
- Payload outputs stay stable throughout ISSUE and GAP, and hold their last value afterwards.

Starvation guard:
- cpu_wait_cnt increments (saturating at MAX_WAIT) on each exchange accept while cpu_req_valid=1.
- It clears on a CPU accept.
- It holds when the CPU is not requesting.

Other rules:
- Requesters hold valid and payload until ready. Dropping valid before ready is legal; nothing is latched.
- Grant counters wrap from 0xFFFF to 0x0000.
- busy = (state != IDLE).

Test Plan:
- Reset → all outputs 0. CPU request {new_max=1, id=5, amt=0x0000_1000} → cpu_req_ready at T. cpu_go high T+1..T+4 with id=5 and amount 0x1000. busy low again at T+9. cpu_grant_count=1.
- Both sides valid continuously, default parameters → grant order EX, EX, EX, CPU, EX, EX, EX, CPU. Grant period 9 cycles. cpu_go and exchange_go never high together.
- Exchange only, 3 back-to-back requests (id=1,2,3, amt=0x00FF) → exchange_go pulses start at T+1, T+10 and T+19. exchange_amount stays 0x00FF and ex_grant_count=3. cpu_wait_cnt stays 0.
- GAP_CYCLES=0, GO_CYCLES=1 → one-cycle go pulses. Sustained accept every 2 cycles.
- HRESETn driven low for one cycle during the 2nd ISSUE cycle → go=0 on that edge, state IDLE, counters 0. A pending valid is accepted on the first cycle after reset is released.
- Preload ex_grant_count to 0xFFFF with 65535 grants (or force the register), then one more grant → count reads 0x0000.
